// File: rtl/step_counter.sv
// step_counter: wrap/saturate up-down step counter with load, saturating mode under STEP_COUNTER_SATURATE_EN
module step_counter #(
  parameter int WIDTH = 5,
  parameter logic [WIDTH-1:0] LIMIT = '1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Down,
  input  logic [WIDTH-1:0] Step,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadValue,
  output logic [WIDTH-1:0] Count,
  output logic             Overflow,
  output logic             Zero
);
  localparam logic [WIDTH:0] LIM = {1'b0, LIMIT};
  localparam logic [WIDTH:0] MOD = LIM + 1'b1;
  logic [WIDTH-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic [WIDTH:0]   base, eff, sum, diff, nxt;
  logic             up_ov, dn_ov;
  always_comb begin
    base       = {1'b0, count_q};
    eff        = {1'b0, Step} % MOD;
    sum        = base + eff;
    diff       = base - eff;
    up_ov      = sum > LIM;
    dn_ov      = eff > base;
`ifdef STEP_COUNTER_SATURATE_EN
    nxt        = Down ? (dn_ov ? '0 : diff) : (up_ov ? LIM : sum);
`else
    nxt        = Down ? (dn_ov ? diff + MOD : diff) : (up_ov ? sum - MOD : sum);
`endif
    count_d    = Load ? (LoadValue > LIMIT ? LIMIT : LoadValue) : Enable ? nxt[WIDTH-1:0] : count_q;
    overflow_d = !Load && Enable && (Down ? dn_ov : up_ov);
  end
  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end
  assign Count    = count_q;
  assign Overflow = overflow_q;
  assign Zero     = count_q == '0;
endmodule

// File: tb/tb_step_counter.sv
// tb_step_counter: directed checks of step_counter at LIMIT=31 and LIMIT=9
module tb_step_counter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_en = 0, a_dn = 0, a_ld = 0, b_en = 0, b_dn = 0, b_ld = 0;
  logic [4:0] a_step = 0, a_lv = 0, b_step = 0, b_lv = 0;
  logic [4:0] a_cnt, b_cnt;
  logic a_ov, a_z, b_ov, b_z;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  step_counter #(.WIDTH(5)) dut_a (
    .Clock(clk), .Reset(rst), .Enable(a_en), .Down(a_dn), .Step(a_step),
    .Load(a_ld), .LoadValue(a_lv), .Count(a_cnt), .Overflow(a_ov), .Zero(a_z)
  );
  step_counter #(.WIDTH(5), .LIMIT(5'd9)) dut_b (
    .Clock(clk), .Reset(rst), .Enable(b_en), .Down(b_dn), .Step(b_step),
    .Load(b_ld), .LoadValue(b_lv), .Count(b_cnt), .Overflow(b_ov), .Zero(b_z)
  );
`ifdef STEP_COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic drv_a(input logic ld, input logic [4:0] lv, input logic en, input logic dn, input logic [4:0] st);
    a_ld = ld; a_lv = lv; a_en = en; a_dn = dn; a_step = st;
    tick();
  endtask
  task automatic drv_b(input logic ld, input logic [4:0] lv, input logic en, input logic dn, input logic [4:0] st);
    b_ld = ld; b_lv = lv; b_en = en; b_dn = dn; b_step = st;
    tick();
  endtask
  initial begin
    tick();
    chk("rst_cnt", a_cnt, 0);
    chk("rst_ov", a_ov, 0);
    chk("rst_zero", a_z, 1);
    chk("rst_cnt_b", b_cnt, 0);
    rst = 0;
    drv_a(0, 0, 1, 0, 1);
    chk("inc1_cnt", a_cnt, 1);
    chk("inc1_zero", a_z, 0);
    chk("inc1_ov", a_ov, 0);
    drv_a(0, 0, 1, 0, 1);
    chk("inc2_cnt", a_cnt, 2);
    drv_a(1, 23, 1, 0, 4);
    chk("load_wins_cnt", a_cnt, 23);
    chk("load_wins_ov", a_ov, 0);
    drv_a(0, 0, 1, 0, 1);
    chk("after_load", a_cnt, 24);
    drv_a(1, 31, 0, 0, 0);
    chk("load_max", a_cnt, 31);
    drv_a(0, 0, 1, 0, 1);
    chk("top_wrap_cnt", a_cnt, SAT ? 31 : 0);
    chk("top_wrap_ov", a_ov, 1);
    drv_a(0, 0, 0, 0, 7);
    chk("idle_ov", a_ov, 0);
    chk("idle_cnt", a_cnt, SAT ? 31 : 0);
    drv_a(1, 2, 0, 0, 0);
    drv_a(0, 0, 1, 1, 5);
    chk("down_wrap_cnt", a_cnt, SAT ? 0 : 29);
    chk("down_wrap_ov", a_ov, 1);
    drv_a(0, 0, 1, 1, 1);
    chk("down1_cnt", a_cnt, SAT ? 0 : 28);
    chk("down1_ov", a_ov, SAT ? 1 : 0);
    drv_a(1, 12, 0, 0, 0);
    drv_a(0, 0, 1, 0, 0);
    chk("step0_cnt", a_cnt, 12);
    chk("step0_ov", a_ov, 0);
    drv_a(0, 0, 1, 0, 31);
    chk("step31_cnt", a_cnt, SAT ? 31 : 11);
    chk("step31_ov", a_ov, 1);
    drv_a(1, 17, 0, 0, 0);
    drv_a(0, 0, 1, 0, 1);
    chk("pre_rst_cnt", a_cnt, 18);
    rst = 1;
    drv_a(1, 5, 1, 0, 1);
    chk("mid_rst_cnt", a_cnt, 0);
    chk("mid_rst_ov", a_ov, 0);
    rst = 0;
    drv_a(0, 0, 1, 0, 3);
    chk("resume_cnt", a_cnt, 3);
    drv_a(0, 0, 0, 0, 0);
    drv_b(1, 8, 0, 0, 0);
    chk("b_load8", b_cnt, 8);
    drv_b(0, 0, 1, 0, 3);
    chk("b_up3_cnt", b_cnt, SAT ? 9 : 1);
    chk("b_up3_ov", b_ov, 1);
    drv_b(0, 0, 1, 0, 12);
    chk("b_up12_cnt", b_cnt, SAT ? 9 : 3);
    chk("b_up12_ov", b_ov, SAT ? 1 : 0);
    drv_b(1, 15, 0, 0, 0);
    chk("b_load_clamp", b_cnt, 9);
    chk("b_load_ov", b_ov, 0);
    drv_b(0, 0, 1, 1, 12);
    chk("b_dn12_cnt", b_cnt, 7);
    chk("b_dn12_ov", b_ov, 0);
    drv_b(0, 0, 1, 1, 9);
    chk("b_dn9_cnt", b_cnt, SAT ? 0 : 8);
    chk("b_dn9_ov", b_ov, 1);
    drv_b(0, 0, 1, 1, 10);
    chk("b_dn10_hold", b_cnt, SAT ? 0 : 8);
    chk("b_dn10_ov", b_ov, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
